// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl -- sequencing control for the multiply/divide unit and the
// architectural HI/LO registers.
//
// Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests while idle, latches the
// operands for the external multiplier/divider, waits for its done strobe,
// and writes the result to HI/LO. A flush while an operation is in flight
// moves to DRAIN, which waits for the unit to finish and throws the result
// away. A wait counter aborts any operation whose done never arrives.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   op_valid, op[2:0]          request (0 MULT,1 MULTU,2 DIV,3 DIVU,4 MTHI,5 MTLO)
//   rs_val, rt_val             operands
//   flush                      discard in-flight result / drop request
//   busy                       high whenever not idle
//   hi, lo                     architectural HI/LO
//   mul_en, mul_unsign         multiplier enable / unsigned select
//   div_start, div_unsign      divider start pulse / unsigned select
//   opa, opb                   latched operands to the units
//   mul_done, mul_result       multiplier completion, {hi,lo} product
//   div_done, div_quot, div_rem divider completion, quotient, remainder
//   timeout_err                one-cycle pulse on timeout abort
module muldiv_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        mul_en,
  output logic        mul_unsign,
  output logic        div_start,
  output logic        div_unsign,
  output logic [31:0] opa,
  output logic [31:0] opb,
  input  logic        mul_done,
  input  logic [63:0] mul_result,
  input  logic        div_done,
  input  logic [31:0] div_quot,
  input  logic [31:0] div_rem,
  output logic        timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DRAIN} state_t;

  localparam int CW = (TIMEOUT < 16) ? 4 : $clog2(TIMEOUT + 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          cnt_last;
  logic          drain_done;

  // cnt is 0 on the first waiting cycle, so the last permitted cycle is
  // TIMEOUT-1: busy stays high for exactly TIMEOUT cycles before an abort.
  assign cnt_last   = (cnt == CW'(TIMEOUT - 1));
  // mul_en is kept high in DRAIN only when the drained op was a multiply,
  // so it doubles as the record of which done strobe to wait for.
  assign drain_done = mul_en ? mul_done : div_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      mul_en      <= 1'b0;
      mul_unsign  <= 1'b0;
      div_start   <= 1'b0;
      div_unsign  <= 1'b0;
      opa         <= '0;
      opb         <= '0;
      timeout_err <= 1'b0;
    end else begin
      div_start   <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (op_valid && !flush) begin
            case (op)
              3'd0, 3'd1: begin
                state      <= S_MUL;
                busy       <= 1'b1;
                mul_en     <= 1'b1;
                mul_unsign <= op[0];
                opa        <= rs_val;
                opb        <= rt_val;
                cnt        <= '0;
              end
              3'd2, 3'd3: begin
                state      <= S_DIV;
                busy       <= 1'b1;
                div_start  <= 1'b1;
                div_unsign <= op[0];
                opa        <= rs_val;
                opb        <= rt_val;
                cnt        <= '0;
              end
              3'd4:    hi <= rs_val;
              3'd5:    lo <= rs_val;
              default: ;
            endcase
          end
        end

        S_MUL: begin
          if (flush) begin
            // done in the flush cycle is already the end of the op
            if (mul_done) begin
              state  <= S_IDLE;
              busy   <= 1'b0;
              mul_en <= 1'b0;
            end else begin
              state  <= S_DRAIN;
            end
            cnt <= '0;
          end else if (mul_done) begin
            {hi, lo} <= mul_result;
            state    <= S_IDLE;
            busy     <= 1'b0;
            mul_en   <= 1'b0;
            cnt      <= '0;
          end else if (cnt_last) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            mul_en      <= 1'b0;
            timeout_err <= 1'b1;
            cnt         <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_DIV: begin
          if (flush) begin
            if (div_done) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= S_DRAIN;
            end
            cnt <= '0;
          end else if (div_done) begin
            // divide-by-zero leaves HI/LO untouched
            if (opb != '0) begin
              lo <= div_quot;
              hi <= div_rem;
            end
            state <= S_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (cnt_last) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
            cnt         <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_DRAIN: begin
          if (drain_done || cnt_last) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            mul_en      <= 1'b0;
            timeout_err <= !drain_done;
            cnt         <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          mul_en <= 1'b0;
          cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, giving the max cycles to wait for mul_done/div_done before aborting.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 op_valid  input  1  operation request, sampled only in IDLE.
REQ-005 op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6/7 reserved, ignored.
REQ-006 rs_val, rt_val  input  32 each  operands (dividend/multiplicand = rs, divisor/multiplier = rt).
REQ-007 flush  input  1  pipeline flush; discard any in-flight result.
REQ-008 busy  output  1  high whenever state != IDLE; CPU stalls MFHI/MFLO and new muldiv ops on it.
REQ-009 hi, lo  output  32 each  architectural HI/LO registers.
REQ-010 mul_en, mul_unsign  output  1 each  multiplier enable and signedness select.
REQ-011 div_start, div_unsign  output  1 each  divider start pulse and signedness select.
REQ-012 opa, opb  output  32 each  latched operands to multiplier and divider.
REQ-013 mul_done  input  1; mul_result  input  64  multiplier completion and product {hi,lo}.
REQ-014 div_done  input  1; div_quot, div_rem  input  32 each  divider completion and results.
REQ-015 timeout_err  output  1  one-cycle pulse when an operation is aborted by timeout.

Function
REQ-016 States SHALL be IDLE, MUL, DIV, DRAIN; encoding free.
REQ-017 IDLE with op_valid and flush low: op 0/1 -> MUL, op 2/3 -> DIV; opa<=rs_val, opb<=rt_val, mul_unsign/div_unsign<=op[0].
REQ-018 IDLE, op 4/5: hi<=rs_val (MTHI) or lo<=rs_val (MTLO) at that edge; state stays IDLE; busy stays low.
REQ-019 op_valid with op 6/7, or any op_valid outside IDLE, SHALL be ignored with no state or register change.
REQ-020 opa/opb SHALL hold stable from acceptance until return to IDLE.
REQ-021 mul_en SHALL be high for every cycle in MUL and low elsewhere.
REQ-022 div_start SHALL pulse high exactly one cycle, the first cycle in DIV.
REQ-023 MUL: mul_done high -> {hi,lo}<=mul_result, state->IDLE at the same edge; busy low the next cycle.
REQ-024 DIV: div_done high -> lo<=div_quot, hi<=div_rem, ->IDLE; if opb==0, hi/lo unchanged but still ->IDLE on div_done.
REQ-025 A 4-bit-or-wider wait counter SHALL clear on entry to MUL/DIV/DRAIN and increment each cycle there.
REQ-026 Counter reaching TIMEOUT without done: ->IDLE, hi/lo unchanged, timeout_err pulses one cycle.
REQ-027 flush in MUL or DIV (done low that cycle) -> DRAIN; mul_en stays high in DRAIN if entered from MUL.
REQ-028 DRAIN: wait for done (or timeout), discard result, ->IDLE; hi/lo never written from DRAIN.
REQ-029 flush and done in the same MUL/DIV cycle: flush wins, result discarded, ->IDLE directly.
REQ-030 flush in IDLE with op_valid: request dropped, including MTHI/MTLO.
REQ-031 done inputs SHALL be ignored in IDLE.

Reset
REQ-032 rst_n low SHALL asynchronously force: state IDLE, hi=lo=0, opa=opb=0, counter 0, all control outputs (busy, mul_en, mul_unsign, div_start, div_unsign, timeout_err) 0.
REQ-033 Reset mid-operation SHALL abandon the operation; later mul_done/div_done SHALL have no effect.

Verification
REQ-034 MULT rs=0xFFFFFFFE(-2), rt=3, mul_done after 6 cycles with product 0xFFFFFFFF_FFFFFFFA -> hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy high exactly 6 cycles, mul_unsign=0.
REQ-035 DIVU rs=100, rt=7 -> div_start one pulse; on div_done lo=14, hi=2; DIV rt=0 -> hi/lo unchanged, busy clears on div_done.
REQ-036 MTHI 0x12345678 then MTLO 0x9ABCDEF0 on back-to-back cycles -> hi/lo updated, busy never asserted.
REQ-037 MULT accepted, flush 2 cycles later, mul_done at cycle 6 -> state DRAIN, hi/lo unchanged, busy drops after done.
REQ-038 DIV with div_done never asserted, TIMEOUT=15 -> IDLE after 15 cycles, one timeout_err pulse, hi/lo unchanged.
REQ-039 rst_n low mid-MUL with hi=5 -> hi=lo=0 and busy=0 immediately; later mul_done ignored.
